prio_arbiter_n: RTL and testbench

Registered, parametrised N-way priority arbiter: the sequential successor of the 8-to-3 priority encoder. It samples a request vector, issues one grant as both binary index and one-hot vector, and holds that grant stable until the consumer accepts it with a valid/ready handshake. Priority is fixed, with the highest index winning, or optionally round-robin. The block sits between a group of requesters and a shared resource, such as a bus, FIFO write port or DMA channel.

---
 rtl/prio_arbiter_n.sv | 143 ++++++++++++++
 tb/tb_prio_arbiter_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_n.sv
// Purpose: registered N-way arbiter, highest request index wins (round-robin when PRIO_ARB_RR_EN is defined).
// Latency: a request sampled at one rising edge is granted immediately after that edge; all outputs are registered.
// Backpressure: the grant stays frozen until grant_ready is seen with grant_valid; that same edge loads the next winner.
module prio_arbiter_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic         vld_q, vld_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] oh_q, oh_d;

  logic         accept;
  logic [W-1:0] win_idx;
  logic         win_found;

  // A handshake only counts while a grant is actually presented.
  assign accept = (state_q == GRANT) && grant_ready;

`ifdef PRIO_ARB_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Pointer moves just below the accepted index; it never moves while a grant is held.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (idx_q == '0) ? LAST_IDX : idx_q - W'(1);
    end
  end

  // Search downward from the post-acceptance pointer so a back-to-back grant already sees the rotation.
  always_comb begin
    logic [W-1:0] cand;
    cand      = ptr_d;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
      cand = (cand == '0) ? LAST_IDX : cand - W'(1);
    end
  end

  // Pointer register; reset value makes the first search identical to fixed priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= LAST_IDX;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: scanning upward lets the highest set index overwrite lower ones.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        win_idx   = W'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  // Next-state and next-output logic; outputs are computed here so they leave the block from flops.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          vld_d   = 1'b1;
          idx_d   = win_idx;
          oh_d    = ONE_HOT0 << win_idx;
        end
      end
      GRANT: begin
        if (accept) begin
          if (win_found) begin
            state_d = GRANT;
            vld_d   = 1'b1;
            idx_d   = win_idx;
            oh_d    = ONE_HOT0 << win_idx;
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            idx_d   = '0;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        idx_d   = '0;
        oh_d    = '0;
      end
    endcase
  end

  // FSM state and registered grant outputs; reset overrides any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign grant_valid  = vld_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = oh_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Bench for prio_arbiter_n: directed vector table, corner sequences and a randomized run against a reference model.
// Two instances (N=8 and N=5) share clock and reset; the mode follows PRIO_ARB_RR_EN.
module tb_prio_arbiter_n;

`ifdef PRIO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic       rdy8;
  logic       v8;
  logic [2:0] idx8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       rdy5;
  logic       v5;
  logic [2:0] idx5;
  logic [4:0] oh5;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  int m8_v, m8_idx, m8_ptr;
  int m5_v, m5_idx, m5_ptr;

  always #5 clk = ~clk;

  prio_arbiter_n #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req8), .grant_ready(rdy8),
    .grant_valid(v8), .grant_idx(idx8), .grant_onehot(oh8)
  );

  prio_arbiter_n #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .req(req5), .grant_ready(rdy5),
    .grant_valid(v5), .grant_idx(idx5), .grant_onehot(oh5)
  );

  typedef struct {
    logic       rs;
    logic [7:0] req;
    logic       rdy;
    logic       ev;
    int         eidx;
    logic [7:0] eoh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic [7:0] r, logic rdy, logic ev, int eidx, logic [7:0] eoh);
    vec_t v;
    v.rs = rs; v.req = r; v.rdy = rdy; v.ev = ev; v.eidx = eidx; v.eoh = eoh;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Winner from the priority rule: walk the priority order list, first requester found wins.
  function automatic int winner(input int n, input logic [7:0] r, input int ptr);
    if (RR) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (ptr - k + n) % n;
        if (r[c]) return c;
      end
    end else begin
      for (int i = n - 1; i >= 0; i--) begin
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic mstep(input int n, input logic [7:0] r, input logic rdy, input logic rs,
                       input int v_i, input int idx_i, input int ptr_i,
                       output int v_o, output int idx_o, output int ptr_o);
    v_o = v_i; idx_o = idx_i; ptr_o = ptr_i;
    if (rs) begin
      v_o = 0; idx_o = 0; ptr_o = n - 1;
    end else if (v_i == 0) begin
      if (r != 0) begin
        v_o = 1; idx_o = winner(n, r, ptr_i);
      end
    end else if (rdy) begin
      if (RR) ptr_o = (idx_i + n - 1) % n;
      if (r != 0) begin
        idx_o = winner(n, r, ptr_o);
      end else begin
        v_o = 0; idx_o = 0;
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    mstep(8, req8, rdy8, rst, m8_v, m8_idx, m8_ptr, m8_v, m8_idx, m8_ptr);
    mstep(5, {3'b000, req5}, rdy5, rst, m5_v, m5_idx, m5_ptr, m5_v, m5_idx, m5_ptr);
    #1;
  endtask

  task automatic check_models();
    chk("rand_valid8", int'(v8), m8_v);
    if (m8_v != 0) chk("rand_idx8", int'(idx8), m8_idx);
    chk("rand_onehot8", int'(oh8), (m8_v != 0) ? (1 << m8_idx) : 0);
    chk("rand_valid5", int'(v5), m5_v);
    if (m5_v != 0) chk("rand_idx5", int'(idx5), m5_idx);
    chk("rand_onehot5", int'(oh5), (m5_v != 0) ? (1 << m5_idx) : 0);
  endtask

  initial begin
    int exp_aa[6];
    int exp_n5[4];
    rst = 1'b1; req8 = 8'h00; rdy8 = 1'b0; req5 = 5'h00; rdy5 = 1'b0;
    m8_v = 0; m8_idx = 0; m8_ptr = 7;
    m5_v = 0; m5_idx = 0; m5_ptr = 4;

    // Reset held with all requests, release, hold/backpressure, drain, reset mid-grant.
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 7, 8'h80));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 8'h04, 1'b0, 1'b1, 2, 8'h04));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 8'h80, 1'b0, 1'b1, 2, 8'h04));
    tbl.push_back(mk(1'b0, 8'h80, 1'b1, 1'b1, 7, 8'h80));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 8'h08, 1'b0, 1'b1, 3, 8'h08));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b0, 0, 8'h00));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 7, 8'h80));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00));

    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rs; req8 = tbl[i].req; rdy8 = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), int'(v8), int'(tbl[i].ev));
      chk($sformatf("vec%0d_idx", i), int'(idx8), tbl[i].ev ? tbl[i].eidx : 0);
      chk($sformatf("vec%0d_onehot", i), int'(oh8), int'(tbl[i].eoh));
    end

    // Back-to-back grants with constant ready: no idle cycles.
    if (RR) exp_aa = '{7, 5, 3, 1, 7, 5};
    else    exp_aa = '{7, 7, 7, 7, 7, 7};
    if (RR) exp_n5 = '{4, 0, 4, 0};
    else    exp_n5 = '{4, 4, 4, 4};
    rst = 1'b1; req8 = 8'h00; rdy8 = 1'b0; req5 = 5'h00; rdy5 = 1'b0;
    step();
    rst = 1'b0; req8 = 8'b10101010; rdy8 = 1'b1; req5 = 5'b10001; rdy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("b2b%0d_valid", i), int'(v8), 1);
      chk($sformatf("b2b%0d_idx", i), int'(idx8), exp_aa[i]);
      if (i < 4) begin
        chk($sformatf("n5_%0d_idx", i), int'(idx5), exp_n5[i]);
        chk($sformatf("n5_%0d_onehot", i), int'(oh5), 1 << exp_n5[i]);
      end
    end

    // Randomized run against the model.
    rst = 1'b1; req8 = 8'h00; rdy8 = 1'b0; req5 = 5'h00; rdy5 = 1'b0;
    step();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       req8 = 8'h00;
        1:       req8 = 8'h01 << $urandom_range(0, 7);
        default: req8 = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       req5 = 5'h00;
        1:       req5 = 5'h01 << $urandom_range(0, 4);
        default: req5 = 5'($urandom);
      endcase
      rdy8 = ($urandom_range(0, 2) != 0);
      rdy5 = ($urandom_range(0, 2) != 0);
      step();
      check_models();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
